// File: rtl/fifo_rd_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkt_ctrl
// Description : Read-side sequencer for a fall-through async FIFO. Pops words
//               into a 2-entry skid buffer and presents them as a valid/ready
//               stream framed into PKT_LEN-beat packets.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_pkt_ctrl #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 256,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             pkt_done,
    output logic [CNTW-1:0]  pkt_cnt,
    output logic             busy
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_FINISH = 2'd2;
    localparam logic [15:0] c_LAST_BEAT = 16'(PKT_LEN - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [15:0]      r_beat_idx;
    logic [15:0]      w_beat_nxt;
    logic [1:0]       r_occ;
    logic [DSIZE-1:0] r_data0;
    logic [DSIZE-1:0] r_data1;
    logic             r_last0;
    logic             r_last1;
    logic             r_pkt_done;
    logic [CNTW-1:0]  r_pkt_cnt;
    logic             w_pop;
    logic             w_hs;
    logic             w_beat_last;

    assign w_pop = ((r_state == c_ST_RUN) || (r_state == c_ST_FINISH)) &&
                   !rempty && (r_occ != 2'd2) && !rst;
    assign w_hs        = (r_occ != 2'd0) && m_axis_tready;
    assign w_beat_last = (r_beat_idx == c_LAST_BEAT);
    assign w_beat_nxt  = !w_pop      ? r_beat_idx :
                         w_beat_last ? 16'd0      : r_beat_idx + 16'd1;

    // Stop decisions look at the beat index after this cycle's pop, so a
    // packet whose last beat is popped on the stop cycle is not reopened.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!en) w_state_nxt = (w_beat_nxt == 16'd0) ? c_ST_IDLE : c_ST_FINISH;
            end
            c_ST_FINISH: begin
                if (en)                        w_state_nxt = c_ST_RUN;
                else if (w_pop && w_beat_last) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_beat_idx <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_idx <= w_beat_nxt;
        end
    end

    // Entry 0 is the head. Pop with handshake only happens at occ==1,
    // since a handshake needs occ!=0 and a pop needs occ!=2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ   <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case ({w_pop, w_hs})
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= rdata;
                        r_last0 <= w_beat_last;
                    end else begin
                        r_data1 <= rdata;
                        r_last1 <= w_beat_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b11: begin
                    r_data0 <= rdata;
                    r_last0 <= w_beat_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_done <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_pkt_done <= w_hs && r_last0;
            if (w_hs && r_last0) r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
        end
    end

    assign rinc          = w_pop;
    assign m_axis_tvalid = (r_occ != 2'd0);
    assign m_axis_tdata  = r_data0;
    assign m_axis_tlast  = (r_occ != 2'd0) && r_last0;
    assign pkt_done      = r_pkt_done;
    assign pkt_cnt       = r_pkt_cnt;
    assign busy          = (r_state != c_ST_IDLE) || (r_occ != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_pkt_ctrl
// Description : Self-checking bench for fifo_rd_pkt_ctrl with a behavioural
//               fall-through FIFO feeding it (PKT_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_pkt_ctrl;

    localparam int DSIZE   = 32;
    localparam int PKT_LEN = 4;
    localparam int CNTW    = 16;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             m_axis_tlast;
    logic             pkt_done;
    logic [CNTW-1:0]  pkt_cnt;
    logic             busy;

    logic             hold = 1'b0;
    logic [DSIZE-1:0] mem [0:255];
    logic [7:0]       rp = 8'd0;
    logic [7:0]       wp = 8'd0;

    int               n_checks = 0;
    int               n_pass = 0;
    int               n_rinc;
    int               n_words;
    int               n_done;
    logic [DSIZE-1:0] exp_word;
    int               exp_beat;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        e_rinc;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_done;
        logic [15:0] e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    assign rempty = hold || (rp == wp);
    assign rdata  = mem[rp];
    always @(posedge clk) if (rinc) rp <= rp + 8'd1;

    fifo_rd_pkt_ctrl #(.DSIZE(DSIZE), .PKT_LEN(PKT_LEN), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rempty        (rempty),
        .rdata         (rdata),
        .rinc          (rinc),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_done      (pkt_done),
        .pkt_cnt       (pkt_cnt),
        .busy          (busy)
    );

    function automatic vec_t v(input logic ven, input logic vrdy, input logic vrinc,
                               input logic vvalid, input logic [31:0] vdata,
                               input logic vlast, input logic vdone,
                               input logic [15:0] vcnt, input logic vbusy);
        vec_t r;
        r.en = ven; r.rdy = vrdy; r.e_rinc = vrinc; r.e_valid = vvalid;
        r.e_data = vdata; r.e_last = vlast; r.e_done = vdone;
        r.e_cnt = vcnt; r.e_busy = vbusy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = DSIZE'(i);
            wp = wp + 8'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; m_axis_tready = 1'b0; hold = 1'b0;
        wp = rp;
        @(negedge clk);
        rst = 1'b0;
        n_rinc = 0; n_words = 0; n_done = 0; exp_word = '0; exp_beat = 0;
    endtask

    // One cycle: drive, then observe pops, pulses and handshakes in order.
    task automatic step(input logic s_en, input logic s_rdy, input logic s_hold);
        @(negedge clk);
        en = s_en; m_axis_tready = s_rdy; hold = s_hold;
        #1;
        if (rinc) n_rinc++;
        if (pkt_done) n_done++;
        if (m_axis_tvalid && m_axis_tready) begin
            chk("hs_tdata", m_axis_tdata, exp_word);
            chk("hs_tlast", 32'(m_axis_tlast), 32'(exp_beat == PKT_LEN - 1));
            exp_word = exp_word + 1;
            exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
            n_words++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = v(T, T, F, F, 32'd0, F, F, 16'd0, F);
        tbl[1]  = v(T, T, T, F, 32'd0, F, F, 16'd0, T);
        tbl[2]  = v(T, T, T, T, 32'd0, F, F, 16'd0, T);
        tbl[3]  = v(T, T, T, T, 32'd1, F, F, 16'd0, T);
        tbl[4]  = v(T, T, T, T, 32'd2, F, F, 16'd0, T);
        tbl[5]  = v(T, T, T, T, 32'd3, T, F, 16'd0, T);
        tbl[6]  = v(T, T, T, T, 32'd4, F, T, 16'd1, T);
        tbl[7]  = v(T, T, T, T, 32'd5, F, F, 16'd1, T);
        tbl[8]  = v(T, T, T, T, 32'd6, F, F, 16'd1, T);
        tbl[9]  = v(T, T, F, T, 32'd7, T, F, 16'd1, T);
        tbl[10] = v(T, T, F, F, 32'd0, F, T, 16'd2, T);
        tbl[11] = v(F, T, F, F, 32'd0, F, F, 16'd2, T);
        tbl[12] = v(F, T, F, F, 32'd0, F, F, 16'd2, F);

        // Reset held with a non-empty FIFO
        load(8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_rinc",   32'(rinc), 32'd0);
            chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
            chk("rst_busy",   32'(busy), 32'd0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
            chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Streaming two back-to-back packets, then stop at a boundary
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            en = tbl[k].en; m_axis_tready = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_rinc", k),   32'(rinc), 32'(tbl[k].e_rinc));
            chk($sformatf("tbl%0d_tvalid", k), 32'(m_axis_tvalid), 32'(tbl[k].e_valid));
            if (tbl[k].e_valid)
                chk($sformatf("tbl%0d_tdata", k), m_axis_tdata, tbl[k].e_data);
            chk($sformatf("tbl%0d_tlast", k),    32'(m_axis_tlast), 32'(tbl[k].e_last));
            chk($sformatf("tbl%0d_pkt_done", k), 32'(pkt_done), 32'(tbl[k].e_done));
            chk($sformatf("tbl%0d_pkt_cnt", k),  32'(pkt_cnt), 32'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_busy", k),     32'(busy), 32'(tbl[k].e_busy));
        end

        // Backpressure: only two words may be popped ahead of the consumer
        do_reset();
        load(8);
        for (int i = 0; i < 10; i++) step(T, F, F);
        chk("bp_rinc_count", 32'(n_rinc), 32'd2);
        chk("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("bp_tdata_held", m_axis_tdata, 32'd0);
        for (int i = 0; i < 14; i++) step(T, T, F);
        chk("bp_words", 32'(n_words), 32'd8);
        chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd2);
        chk("bp_pkt_done_pulses", 32'(n_done), 32'd2);

        // Disable mid-packet: the packet completes, the rest stays queued
        do_reset();
        load(8);
        for (int i = 0; i < 3; i++) step(T, T, F);
        for (int i = 0; i < 10; i++) step(F, T, F);
        chk("dis_rinc_count", 32'(n_rinc), 32'd4);
        chk("dis_words", 32'(n_words), 32'd4);
        chk("dis_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("dis_fifo_left", 32'(wp - rp), 32'd4);
        chk("dis_busy", 32'(busy), 32'd0);

        // FIFO runs dry mid-packet; framing must survive the gap
        do_reset();
        load(8);
        for (int i = 0; i < 3; i++) step(T, T, F);
        for (int i = 0; i < 5; i++) begin
            step(T, T, T);
            chk("gap_rinc", 32'(rinc), 32'd0);
            if (i > 0) chk("gap_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        for (int i = 0; i < 14; i++) step(T, T, F);
        chk("gap_words", 32'(n_words), 32'd8);
        chk("gap_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Reset with a full skid buffer mid-packet
        do_reset();
        load(16);
        for (int i = 0; i < 4; i++) step(T, F, F);
        chk("mrst_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("mrst_pre_rinc", 32'(n_rinc), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        exp_word = 32'd2; exp_beat = 0; n_words = 0; n_done = 0;
        for (int i = 0; i < 22; i++) step(T, T, F);
        chk("mrst_words", 32'(n_words), 32'd14);
        chk("mrst_pkt_cnt", 32'(pkt_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
